// File: rtl/spec_rob_pkg.sv
// Shared widths, instruction-type encodings and the default-width entry layout
// for the speculative result buffer.
package spec_rob_pkg;

    localparam int DEF_DEPTH  = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_PC_W   = 32;
    localparam int DEF_REG_W  = 5;
    localparam int DEF_TYPE_W = 2;

    typedef enum logic [DEF_TYPE_W-1:0] {
        ITYPE_ALU    = 2'd0,
        ITYPE_LOAD   = 2'd1,
        ITYPE_STORE  = 2'd2,
        ITYPE_BRANCH = 2'd3
    } itype_e;

    typedef struct packed {
        logic                  valid;
        logic                  spec_valid;
        logic [DEF_REG_W-1:0]  rd;
        logic [DEF_PC_W-1:0]   pc;
        logic [DEF_TYPE_W-1:0] itype;
        logic [DEF_DATA_W-1:0] data;
    } rob_entry_t;

endpackage

// File: rtl/spec_rob_ptr.sv
// Head/tail/occupancy bookkeeping for the circular buffer; flush overrides
// any allocation or commit in the same cycle.
module spec_rob_ptr
    import spec_rob_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             alloc_fire_i,
    input  logic             commit_fire_i,
    output logic [TAG_W-1:0] head_o,
    output logic [TAG_W-1:0] tail_o,
    output logic [TAG_W:0]   count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;

    // DEPTH is a power of two, so the natural pointer overflow is the wrap.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (alloc_fire_i)  tail_d = tail_q + TAG_W'(1);
            if (commit_fire_i) head_d = head_q + TAG_W'(1);
            case ({alloc_fire_i, commit_fire_i})
                2'b10:   count_d = count_q + (TAG_W+1)'(1);
                2'b01:   count_d = count_q - (TAG_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign tail_o  = tail_q;
    assign count_o = count_q;
    assign full_o  = (count_q == (TAG_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/spec_rob.sv
// Circular speculative-result buffer: in-order allocate, out-of-order result
// writes by tag, two bypassed read ports and in-order commit from the head.
module spec_rob
    import spec_rob_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int PC_W   = DEF_PC_W,
    parameter int REG_W  = DEF_REG_W,
    parameter int TYPE_W = DEF_TYPE_W,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [REG_W-1:0]  alloc_rd,
    input  logic [PC_W-1:0]   alloc_pc,
    input  logic [TYPE_W-1:0] alloc_type,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              upd_valid,
    input  logic [TAG_W-1:0]  upd_tag,
    input  logic [DATA_W-1:0] upd_data,
    input  logic [TAG_W-1:0]  rd_tag1,
    input  logic [TAG_W-1:0]  rd_tag2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_spec_valid1,
    output logic              rd_spec_valid2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    output logic              commit_valid,
    input  logic              commit_ready,
    output logic [REG_W-1:0]  commit_rd,
    output logic [PC_W-1:0]   commit_pc,
    output logic [TYPE_W-1:0] commit_type,
    output logic [DATA_W-1:0] commit_data,
    output logic [TAG_W:0]    count,
    output logic              full,
    output logic              empty
);

    typedef struct packed {
        logic              valid;
        logic              spec_valid;
        logic [REG_W-1:0]  rd;
        logic [PC_W-1:0]   pc;
        logic [TYPE_W-1:0] itype;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [TAG_W-1:0] head, tail;
    logic             alloc_fire, commit_fire, upd_write;
    entry_t           head_entry, alloc_entry;

    spec_rob_ptr #(.DEPTH(DEPTH)) u_ptr (
        .clock         (clock),
        .reset         (reset),
        .flush_i       (flush),
        .alloc_fire_i  (alloc_fire),
        .commit_fire_i (commit_fire),
        .head_o        (head),
        .tail_o        (tail),
        .count_o       (count),
        .full_o        (full),
        .empty_o       (empty)
    );

    assign alloc_ready = ~full;
    assign alloc_tag   = tail;
    assign alloc_fire  = alloc_valid & alloc_ready;

    assign head_entry   = mem_q[head];
    assign commit_valid = head_entry.valid & head_entry.spec_valid;
    assign commit_fire  = commit_valid & commit_ready;
    assign commit_rd    = commit_valid ? head_entry.rd    : '0;
    assign commit_pc    = commit_valid ? head_entry.pc    : '0;
    assign commit_type  = commit_valid ? head_entry.itype : '0;
    assign commit_data  = commit_valid ? head_entry.data  : '0;

    // A result racing the retirement of its own entry is dropped.
    assign upd_write = upd_valid & mem_q[upd_tag].valid & ~(commit_fire & (upd_tag == head));

    always_comb begin
        alloc_entry            = '0;
        alloc_entry.valid      = 1'b1;
        alloc_entry.rd         = alloc_rd;
        alloc_entry.pc         = alloc_pc;
        alloc_entry.itype      = alloc_type;
    end

    // alloc_fire implies not full and commit_fire implies not empty, so
    // head and tail never collide; tail is never valid so updates miss it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i].valid      <= 1'b0;
                mem_q[i].spec_valid <= 1'b0;
            end
        end else begin
            if (upd_write) begin
                mem_q[upd_tag].data       <= upd_data;
                mem_q[upd_tag].spec_valid <= 1'b1;
            end
            if (commit_fire) mem_q[head].valid <= 1'b0;
            if (alloc_fire)  mem_q[tail]       <= alloc_entry;
        end
    end

    logic [TAG_W-1:0]  rtag  [2];
    logic [DATA_W-1:0] rdata [2];
    logic              rspec [2];
    logic              rbusy [2];

    assign rtag[0] = rd_tag1;
    assign rtag[1] = rd_tag2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            entry_t e;
            logic   hit;
            assign e         = mem_q[rtag[gi]];
            assign hit       = upd_valid & e.valid & (rtag[gi] == upd_tag);
            assign rbusy[gi] = e.valid;
            assign rspec[gi] = e.valid & (hit | e.spec_valid);
            assign rdata[gi] = !e.valid ? '0 : (hit ? upd_data : e.data);
        end
    endgenerate

    assign rd_data1       = rdata[0];
    assign rd_data2       = rdata[1];
    assign rd_spec_valid1 = rspec[0];
    assign rd_spec_valid2 = rspec[1];
    assign rd_busy1       = rbusy[0];
    assign rd_busy2       = rbusy[1];

endmodule
